// File: rtl/fp16_seq_pkg.sv
// Shared types and constants for the FP16 operation sequencer.
package fp16_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StGap,
        StLoadB,
        StIssue,
        StWait,
        StResp
    } seq_state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_NAN     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ILLEGAL = 2'd3;

    localparam logic [15:0] FP16_QNAN     = 16'h7E00;
    localparam logic [4:0]  FP16_EXP_ONES = 5'h1F;

    // NaN: all-ones exponent with a non-zero mantissa (infinity is not NaN).
    function automatic logic fp16_is_nan(input logic [15:0] v);
        return (v[14:10] == FP16_EXP_ONES) && (v[9:0] != 10'd0);
    endfunction

endpackage

// File: rtl/watchdog_counter.sv
// Non-wrapping cycle counter that flags when it has reached LIMIT-1.
module watchdog_counter #(
    parameter int unsigned LIMIT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam int unsigned W = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_count;

    // Count up while enabled, holding at the last value instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/fp16_op_sequencer.sv
// Sequences one FP16 operation: unpack both operands through the shared load
// unit, issue to the ALU under a watchdog and return the result.
module fp16_op_sequencer
    import fp16_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [15:0] i_req_a,
    input  logic [15:0] i_req_b,
    input  logic [1:0]  i_req_op,
    output logic        o_load_enable,
    output logic [15:0] o_load_data,
    input  logic        i_load_valid,
    input  logic        i_load_sign,
    input  logic [4:0]  i_load_exp,
    input  logic [9:0]  i_load_mant,
    output logic        o_alu_start,
    output logic [1:0]  o_alu_op,
    output logic [15:0] o_alu_a,
    output logic [15:0] o_alu_b,
    input  logic        i_alu_done,
    input  logic [15:0] i_alu_result,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [15:0] o_rsp_result,
    output logic [1:0]  o_rsp_status
);

    seq_state_e  r_state;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [1:0]  r_op;
    logic [15:0] r_opa;
    logic [15:0] r_opb;
    logic [15:0] r_rsp_result;
    logic [1:0]  r_rsp_status;
    logic        r_alu_start;

    logic [15:0] w_load_word;
    logic        w_wd_clear;
    logic        w_wd_inc;
    logic        w_wd_expired;

    assign w_load_word = {i_load_sign, i_load_exp, i_load_mant};
    assign w_wd_clear  = (r_state == StIssue);
    assign w_wd_inc    = (r_state == StWait) && !i_alu_done;

    watchdog_counter #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_wd_clear),
        .i_inc     (w_wd_inc),
        .o_expired (w_wd_expired)
    );

    // Main sequencing FSM with all captures and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_rsp_result <= '0;
            r_rsp_status <= '0;
            r_alu_start  <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_a     <= i_req_a;
                        r_b     <= i_req_b;
                        r_op    <= i_req_op;
                        r_state <= StLoadA;
                    end
                end
                StLoadA: begin
                    if (i_load_valid) begin
                        r_opa   <= w_load_word;
                        r_state <= StGap;
                    end
                end
                // One idle cycle so the load unit sees a fresh enable edge.
                StGap: r_state <= StLoadB;
                StLoadB: begin
                    if (i_load_valid) begin
                        r_opb       <= w_load_word;
                        // Pre-decide the start pulse so it lands in ISSUE only.
                        r_alu_start <= (r_op != OP_ILL) && !fp16_is_nan(r_opa) &&
                                       !fp16_is_nan(w_load_word);
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (r_op == OP_ILL) begin
                        r_rsp_result <= FP16_QNAN;
                        r_rsp_status <= ST_ILLEGAL;
                        r_state      <= StResp;
                    end else if (fp16_is_nan(r_opa) || fp16_is_nan(r_opb)) begin
                        r_rsp_result <= FP16_QNAN;
                        r_rsp_status <= ST_NAN;
                        r_state      <= StResp;
                    end else begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    // Completion beats an expiring watchdog in the same cycle.
                    if (i_alu_done) begin
                        r_rsp_result <= i_alu_result;
                        r_rsp_status <= ST_OK;
                        r_state      <= StResp;
                    end else if (w_wd_expired) begin
                        r_rsp_result <= FP16_QNAN;
                        r_rsp_status <= ST_TIMEOUT;
                        r_state      <= StResp;
                    end
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Outputs are registers or pure decodes of the state register.
    always_comb begin
        o_load_data = 16'd0;
        if (r_state == StLoadA) begin
            o_load_data = r_a;
        end else if (r_state == StLoadB) begin
            o_load_data = r_b;
        end
    end

    assign o_req_ready   = (r_state == StIdle);
    assign o_load_enable = (r_state == StLoadA) || (r_state == StLoadB);
    assign o_alu_start   = r_alu_start;
    assign o_alu_op      = r_op;
    assign o_alu_a       = r_opa;
    assign o_alu_b       = r_opb;
    assign o_rsp_valid   = (r_state == StResp);
    assign o_rsp_result  = r_rsp_result;
    assign o_rsp_status  = r_rsp_status;

endmodule

// File: tb/tb_fp16_op_sequencer.sv
// Randomized bench for fp16_op_sequencer with load-unit and ALU models.
module tb_fp16_op_sequencer;

    localparam int unsigned TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic [1:0]  req_op;
    logic        load_enable, load_valid, load_sign;
    logic [15:0] load_data;
    logic [4:0]  load_exp;
    logic [9:0]  load_mant;
    logic        alu_start, alu_done;
    logic [1:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_status;

    int n_cmp = 0;
    int n_err = 0;

    int          cfg_load_lat = 1;
    int          cfg_alu_lat = 1;
    logic [15:0] cfg_alu_res = 16'h0;
    int          load_cnt = 0;
    logic        load_prev = 1'b0;
    int          alu_cnt = 0;

    fp16_op_sequencer #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_op     (req_op),
        .o_load_enable(load_enable),
        .o_load_data  (load_data),
        .i_load_valid (load_valid),
        .i_load_sign  (load_sign),
        .i_load_exp   (load_exp),
        .i_load_mant  (load_mant),
        .o_alu_start  (alu_start),
        .o_alu_op     (alu_op),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_done   (alu_done),
        .i_alu_result (alu_result),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_rsp_status (rsp_status)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_is_nan(input logic [15:0] v);
        return (((v >> 10) & 16'h1F) == 16'h1F) && ((v & 16'h3FF) != 0);
    endfunction

    // Load unit: valid after cfg_load_lat enabled cycles; noise while idle.
    always @(posedge clk) begin
        #1;
        if (load_enable) begin
            load_cnt   = load_prev ? load_cnt + 1 : 0;
            load_valid = (load_cnt == cfg_load_lat);
            {load_sign, load_exp, load_mant} = load_valid ? load_data : 16'($urandom);
        end else begin
            load_valid = 1'($urandom);
            {load_sign, load_exp, load_mant} = 16'($urandom);
        end
        load_prev = load_enable;
    end

    // ALU: done pulse cfg_alu_lat cycles after start (0 = never); not reset-aware.
    always @(posedge clk) begin
        #1;
        alu_done   = 1'b0;
        alu_result = 16'($urandom);
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_done   = 1'b1;
                alu_result = cfg_alu_res;
            end
        end
        if (alu_start && cfg_alu_lat > 0) alu_cnt = cfg_alu_lat;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_load_en"}, 32'(load_enable), 32'd0);
        check_eq({tag, "_load_data"}, 32'(load_data), 32'd0);
        check_eq({tag, "_alu_start"}, 32'(alu_start), 32'd0);
        check_eq({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        check_eq({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check_eq({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        check_eq({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
    endtask

    // One full request/response; expectations come from the operation rules.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                           input int l_lat, input int a_lat, input logic [15:0] res,
                           input int hold, input bit keep_valid);
        logic [15:0] exp_res;
        logic [1:0]  exp_st;
        int          issue_cyc, exp_cyc, exp_starts, c, starts, late;
        bit          got, exp_en;
        issue_cyc = 4 + 2 * l_lat;
        if (op == 2'd3) begin
            exp_res = 16'h7E00; exp_st = 2'd3; exp_cyc = issue_cyc + 1; exp_starts = 0;
        end else if (ref_is_nan(a) || ref_is_nan(b)) begin
            exp_res = 16'h7E00; exp_st = 2'd1; exp_cyc = issue_cyc + 1; exp_starts = 0;
        end else if (a_lat >= 1 && a_lat <= int'(TIMEOUT)) begin
            exp_res = res; exp_st = 2'd0; exp_cyc = issue_cyc + 1 + a_lat; exp_starts = 1;
        end else begin
            exp_res = 16'h7E00; exp_st = 2'd2; exp_cyc = issue_cyc + 1 + int'(TIMEOUT);
            exp_starts = 1;
        end
        cfg_load_lat = l_lat;
        cfg_alu_lat  = a_lat;
        cfg_alu_res  = res;
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        step();
        if (!keep_valid) req_valid = 1'b0;
        req_a = 16'($urandom); req_b = 16'($urandom); req_op = 2'($urandom);
        c = 1; starts = 0; got = 1'b0;
        while (!got && c < 300) begin
            if (keep_valid) check_eq("req_ready_busy", 32'(req_ready), 32'd0);
            exp_en = (c <= 1 + l_lat) || (c >= 3 + l_lat && c <= 3 + 2 * l_lat);
            check_eq("load_enable", 32'(load_enable), 32'(exp_en));
            if (exp_en) check_eq("load_data", 32'(load_data), 32'((c <= 1 + l_lat) ? a : b));
            if (alu_start) begin
                starts++;
                check_eq("start_cycle", c, issue_cyc);
                check_eq("alu_a", 32'(alu_a), 32'(a));
                check_eq("alu_b", 32'(alu_b), 32'(b));
                check_eq("alu_op", 32'(alu_op), 32'(op));
            end
            if (rsp_valid) got = 1'b1;
            else begin
                step();
                c++;
            end
        end
        check_eq("rsp_seen", 32'(got), 32'd1);
        check_eq("rsp_cycle", c, exp_cyc);
        check_eq("alu_starts", starts, exp_starts);
        check_eq("rsp_result", 32'(rsp_result), 32'(exp_res));
        check_eq("rsp_status", 32'(rsp_status), 32'(exp_st));
        for (int h = 0; h < hold; h++) begin
            step();
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_result", 32'(rsp_result), 32'(exp_res));
            check_eq("hold_status", 32'(rsp_status), 32'(exp_st));
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
            check_eq("hold_alu_a", 32'(alu_a), 32'(a));
            check_eq("hold_alu_b", 32'(alu_b), 32'(b));
            check_eq("hold_alu_op", 32'(alu_op), 32'(op));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_req_ready", 32'(req_ready), 32'd1);
        // Any late alu_done must not raise a second response.
        late = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid) late++;
        end
        check_eq("no_extra_rsp", late, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int          spurious;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        rsp_ready = 1'b0; load_valid = 1'b0; alu_done = 1'b0; alu_result = '0;
        {load_sign, load_exp, load_mant} = 16'h0;
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        req_valid = 1'b0;
        rst_n = 1'b1;
        step();

        run_txn(16'h3C00, 16'h4000, 2'd0, 1, 3, 16'h4200, 0, 1'b0);
        run_txn(16'h7E01, 16'h3C00, 2'd2, 1, 3, 16'h1234, 0, 1'b0);
        run_txn(16'h7E01, 16'h3C00, 2'd3, 1, 3, 16'h1234, 0, 1'b0);
        run_txn(16'h3C00, 16'h4000, 2'd1, 1, 0, 16'h1111, 0, 1'b0);
        run_txn(16'h3C00, 16'h4000, 2'd0, 1, 10, 16'h2222, 0, 1'b0);
        run_txn(16'h3C00, 16'h4000, 2'd2, 1, 8, 16'h3333, 0, 1'b0);
        run_txn(16'h4400, 16'hC000, 2'd1, 1, 2, 16'h4A00, 5, 1'b1);

        // Reset pulse while waiting on the ALU.
        cfg_load_lat = 1; cfg_alu_lat = 20; cfg_alu_res = 16'h5555;
        req_valid = 1'b1; req_a = 16'h3C00; req_b = 16'h3C00; req_op = 2'd0;
        step();
        req_valid = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        step();
        step();
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (rsp_valid) spurious++;
        end
        check_eq("after_reset_no_rsp", spurious, 0);
        run_txn(16'h3800, 16'h3800, 2'd2, 1, 1, 16'h3400, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra[14:10] = 5'h1F;
            if ($urandom_range(0, 3) == 0) rb[14:10] = 5'h1F;
            run_txn(ra, rb, 2'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                    int'($urandom_range(0, 11)), 16'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
